// File: rtl/elevator_pkg.sv
// Shared types, default timing constants and direction-mask helpers for the
// SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  // Widest building the mask helpers have to cover.
  localparam int MAX_FLOORS = 16;

  // 1 s of travel per floor and 3 s of door dwell at 100 MHz.
  localparam int DEF_TRAVEL_CYCLES = 100_000_000;
  localparam int DEF_DOOR_CYCLES   = 300_000_000;

  // Mask of floors strictly above (up=1) or strictly below (up=0) fl.
  function automatic logic [MAX_FLOORS-1:0] side_mask(input logic [3:0] fl,
                                                      input logic       up);
    logic [MAX_FLOORS-1:0] all_ones;
    all_ones = '1;
    if (up) side_mask = all_ones << ({1'b0, fl} + 5'd1);
    else    side_mask = ~(all_ones << fl);
  endfunction

  // True when any pending call lies on the chosen side of fl.
  function automatic logic any_on_side(input logic [MAX_FLOORS-1:0] pend,
                                       input logic [3:0]            fl,
                                       input logic                  up);
    return |(pend & side_mask(fl, up));
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Cycle counter running 0..LAST while enabled. Clear has priority and
// forces the count to 0; tc pulses on the enabled cycle that holds LAST,
// and the count reloads to 0 on the following edge.
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int               CNT_W = 32,
  parameter logic [CNT_W-1:0] LAST  = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = en && !clr && (count == LAST);

  // Count register: clear, reload at terminal count, otherwise increment.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    if (!reset)      count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= tc ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator car controller. Latches floor calls, keeps travelling
// in the current direction while calls remain ahead, reverses through IDLE,
// and times travel and door dwell with two elevator_timer instances.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  state_t                  state, state_next;
  logic [FLOOR_W-1:0]      floor_next, floor_step;
  logic                    dir_next, arrive_next;
  logic [NUM_FLOORS-1:0]   pending_next;
  logic [MAX_FLOORS-1:0]   pend_ext;
  logic [3:0]              floor_idx, step_idx;
  logic                    here_pend, ahead_any, behind_any;
  logic                    at_end, arrival, new_here, ahead_new;
  logic                    req_here, travel_tc, door_tc, door_clr;

  // Decision terms, all based on registered pending.
  assign pend_ext   = MAX_FLOORS'(pending);
  assign floor_idx  = 4'(floor);
  assign step_idx   = 4'(floor_step);
  assign here_pend  = pending[floor];
  assign req_here   = req[floor];
  assign ahead_any  = any_on_side(pend_ext, floor_idx, dir_up);
  assign behind_any = any_on_side(pend_ext, floor_idx, !dir_up);

  // Neighbouring floor in the travel direction; at_end blocks stepping off
  // the shaft even though MOVE is only entered with calls ahead.
  assign at_end     = dir_up ? (floor == FLOOR_W'(NUM_FLOORS - 1)) : (floor == '0);
  assign floor_step = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
  assign arrival    = travel_tc && !at_end;
  // A call pressed at the arrival floor on the arrival edge counts as served.
  assign new_here   = pending[floor_step] | req[floor_step];
  assign ahead_new  = any_on_side(pend_ext, step_idx, dir_up);

  // Door dwell restarts while held or when the current floor is re-called.
  assign door_clr = (state != ST_DOOR) || door_hold || req_here;

  elevator_timer #(
    .CNT_W (CNT_W),
    .LAST  (CNT_W'(TRAVEL_CYCLES - 1))
  ) u_travel (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_MOVE),
    .en    (state == ST_MOVE),
    .tc    (travel_tc)
  );

  elevator_timer #(
    .CNT_W (CNT_W),
    .LAST  (CNT_W'(DOOR_CYCLES - 1))
  ) u_door (
    .clk   (clk),
    .reset (reset),
    .clr   (door_clr),
    .en    (state == ST_DOOR),
    .tc    (door_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: SCAN decisions in IDLE, arrival decisions in MOVE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (here_pend)                     state_next = ST_DOOR;
        else if (ahead_any || behind_any)  state_next = ST_MOVE;
      end
      ST_MOVE: begin
        if (arrival) begin
          if (new_here)       state_next = ST_DOOR;
          else if (ahead_new) state_next = ST_MOVE;
          else                state_next = ST_IDLE;
        end else if (travel_tc) begin
          state_next = ST_IDLE;
        end
      end
      ST_DOOR: begin
        if (door_tc) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: call latching, floor stepping, direction flip.
  always_comb begin
    floor_next   = floor;
    dir_next     = dir_up;
    arrive_next  = 1'b0;
    pending_next = pending | req;
    case (state)
      ST_IDLE: begin
        if (here_pend)                      pending_next[floor] = 1'b0;
        else if (!ahead_any && behind_any)  dir_next = !dir_up;
      end
      ST_MOVE: begin
        if (arrival) begin
          floor_next  = floor_step;
          arrive_next = 1'b1;
          if (new_here) pending_next[floor_step] = 1'b0;
        end
      end
      ST_DOOR: begin
        // A call for the open floor restarts the dwell instead of latching.
        pending_next[floor] = pending[floor];
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      floor   <= '0;
      dir_up  <= 1'b1;
      arrive  <= 1'b0;
      pending <= '0;
    end else begin
      floor   <= floor_next;
      dir_up  <= dir_next;
      arrive  <= arrive_next;
      pending <= pending_next;
    end
  end

  // State-decoded outputs.
  always_comb begin
    moving    = (state == ST_MOVE);
    door_open = (state == ST_DOOR);
  end

endmodule
